player_ctl: RTL and testbench

PLAYER_CTL -- requirements
Module: player_ctl

---
 rtl/player_ctl.sv | 169 ++++++++++++++++
 tb/tb_player_ctl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/player_ctl.sv
// Player sprite position controller: horizontal walking with edge saturation and a
// three-state jump/gravity machine, advanced once per frame on the rising edge of vblnk.
module player_ctl #(
  parameter int unsigned X_START  = 10,
  parameter int unsigned X_MIN    = 0,
  parameter int unsigned X_MAX    = 958,
  parameter int unsigned GROUND_Y = 292,
  parameter int unsigned STEP     = 4,
  parameter int unsigned JUMP_V0  = 16,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned VMAX     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       en,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] player_xpos,
  output logic [9:0] player_ypos,
  output logic       airborne
);

  localparam int unsigned XW = 10;
  localparam int unsigned VW = 6;
  localparam int unsigned AW = 11;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [XW-1:0]   y_q, y_d;
  logic [VW-1:0]   vel_q, vel_d;
  logic            airborne_q, airborne_d;
  logic            vblnk_q;

  logic            tick_c;
  logic            step_c;
  logic [AW-1:0]   x_ext_c;
  logic [AW-1:0]   y_ext_c;
  logic [AW-1:0]   vel_ext_c;
  logic [AW-1:0]   x_left_c;
  logic [AW-1:0]   x_right_c;
  logic [AW-1:0]   x_sum_c;
  logic [AW-1:0]   vel_sum_c;
  logic [AW-1:0]   vel_fall_c;
  logic [AW-1:0]   y_fall_c;

  assign tick_c = vblnk & ~vblnk_q;
  assign step_c = tick_c & en;

  // Horizontal candidates, all in 11 bits so the left step can never wrap below zero
  always_comb begin
    x_ext_c   = AW'(x_q);
    x_sum_c   = x_ext_c + AW'(STEP);
    if (x_ext_c < (AW'(X_MIN) + AW'(STEP))) begin
      x_left_c = AW'(X_MIN);
    end else begin
      x_left_c = x_ext_c - AW'(STEP);
    end
    if (x_sum_c > AW'(X_MAX)) begin
      x_right_c = AW'(X_MAX);
    end else begin
      x_right_c = x_sum_c;
    end
  end

  // Fall candidates: capped velocity and the resulting landing test operand
  always_comb begin
    y_ext_c   = AW'(y_q);
    vel_ext_c = AW'(vel_q);
    vel_sum_c = vel_ext_c + AW'(GRAVITY);
    if (vel_sum_c > AW'(VMAX)) begin
      vel_fall_c = AW'(VMAX);
    end else begin
      vel_fall_c = vel_sum_c;
    end
    y_fall_c = y_ext_c + vel_fall_c;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    airborne_d = airborne_q;

    if (step_c) begin
      if (btn_left && !btn_right) begin
        x_d = XW'(x_left_c);
      end else if (btn_right && !btn_left) begin
        x_d = XW'(x_right_c);
      end

      case (state_q)
        ST_GROUND: begin
          if (btn_jump) begin
            state_d = ST_RISE;
            vel_d   = VW'(JUMP_V0);
          end else begin
            y_d   = XW'(GROUND_Y);
            vel_d = '0;
          end
        end
        ST_RISE: begin
          if (vel_ext_c > y_ext_c) begin
            // Ceiling hit: clamp to the top and start falling from rest
            y_d     = '0;
            vel_d   = '0;
            state_d = ST_FALL;
          end else begin
            y_d = XW'(y_ext_c - vel_ext_c);
            if (vel_ext_c <= AW'(GRAVITY)) begin
              vel_d   = '0;
              state_d = ST_FALL;
            end else begin
              vel_d = VW'(vel_ext_c - AW'(GRAVITY));
            end
          end
        end
        ST_FALL: begin
          if (y_fall_c >= AW'(GROUND_Y)) begin
            y_d     = XW'(GROUND_Y);
            vel_d   = '0;
            state_d = ST_GROUND;
          end else begin
            y_d   = XW'(y_fall_c);
            vel_d = VW'(vel_fall_c);
          end
        end
        default: begin
          y_d     = XW'(GROUND_Y);
          vel_d   = '0;
          state_d = ST_GROUND;
        end
      endcase

      airborne_d = (state_d != ST_GROUND);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q    <= 1'b0;
      state_q    <= ST_GROUND;
      x_q        <= XW'(X_START);
      y_q        <= XW'(GROUND_Y);
      vel_q      <= '0;
      airborne_q <= 1'b0;
    end else begin
      vblnk_q    <= vblnk;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vel_q      <= vel_d;
      airborne_q <= airborne_d;
    end
  end

  assign player_xpos = x_q;
  assign player_ypos = y_q;
  assign airborne    = airborne_q;

endmodule

// File: tb/tb_player_ctl.sv
// Directed bench for player_ctl: walking, edge saturation, a full jump with mid-air
// button noise and an enable freeze, held-jump retrigger, and reset mid-jump.
module tb_player_ctl;

  logic       clk;
  logic       rst;
  logic       vblnk;
  logic       en;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic [9:0] player_xpos;
  logic [9:0] player_ypos;
  logic       airborne;

  int n_checks;
  int n_fails;

  player_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .en         (en),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .player_xpos(player_xpos),
    .player_ypos(player_ypos),
    .airborne   (airborne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int ea);
    check({tag, ".x"}, int'(player_xpos), ex);
    check({tag, ".y"}, int'(player_ypos), ey);
    check({tag, ".air"}, int'(airborne), ea);
  endtask

  // One frame: vblnk high for one cycle, then low; returns at a negedge after the update
  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  function automatic int rise_y(input int k);
    return 292 - (16 * k - (k * (k - 1)) / 2);
  endfunction

  function automatic int fall_y(input int j);
    return 156 + (j * (j + 1)) / 2;
  endfunction

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    vblnk     = 1'b0;
    en        = 1'b1;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_jump  = 1'b0;

    do_reset();
    check_pos("reset", 10, 292, 0);

    // Walk right for ten frames
    btn_right = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      frame();
      check_pos($sformatf("walk%0d", k), 10 + 4 * k, 292, 0);
    end
    btn_right = 1'b0;

    // No tick without a vblnk edge
    repeat (5) @(negedge clk);
    check_pos("idle", 50, 292, 0);

    // Left saturation at X_MIN
    do_reset();
    btn_left = 1'b1;
    frame();
    frame();
    check("left_to2", int'(player_xpos), 2);
    frame();
    check("left_sat0", int'(player_xpos), 0);
    frame();
    check("left_hold0", int'(player_xpos), 0);
    btn_left = 1'b0;

    // Right saturation at X_MAX
    btn_right = 1'b1;
    repeat (239) frame();
    check("right_to956", int'(player_xpos), 956);
    frame();
    check("right_sat958", int'(player_xpos), 958);
    frame();
    check("right_hold958", int'(player_xpos), 958);
    btn_left = 1'b1;
    frame();
    check("both_hold", int'(player_xpos), 958);
    btn_left  = 1'b0;
    btn_right = 1'b0;

    // Full jump with button noise in RISE and an enable freeze in FALL
    do_reset();
    btn_jump = 1'b1;
    frame();
    btn_jump = 1'b0;
    check_pos("jump_load", 10, 292, 1);
    for (int k = 1; k <= 16; k++) begin
      btn_jump  = (k >= 3 && k <= 5);
      btn_left  = (k >= 3 && k <= 5);
      btn_right = (k >= 3 && k <= 5);
      frame();
      check_pos($sformatf("rise%0d", k), 10, rise_y(k), 1);
    end
    btn_jump  = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    check("apex", int'(player_ypos), 156);
    for (int j = 1; j <= 16; j++) begin
      if (j == 5) begin
        en        = 1'b0;
        btn_right = 1'b1;
        btn_jump  = 1'b1;
        for (int f = 1; f <= 5; f++) begin
          frame();
          check_pos($sformatf("freeze%0d", f), 10, fall_y(4), 1);
        end
        en        = 1'b1;
        btn_right = 1'b0;
        btn_jump  = 1'b0;
      end
      if (j == 16) btn_jump = 1'b1;
      frame();
      check_pos($sformatf("fall%0d", j), 10, fall_y(j), (j < 16) ? 1 : 0);
    end
    // Held jump relaunches on the first tick after landing
    frame();
    check_pos("relaunch", 10, 292, 1);
    btn_jump = 1'b0;
    frame();
    check_pos("relaunch_rise1", 10, rise_y(1), 1);

    // Reset at RISE tick 8, with vblnk held across the release
    do_reset();
    btn_jump = 1'b1;
    frame();
    btn_jump  = 1'b0;
    btn_right = 1'b1;
    for (int k = 1; k <= 7; k++) frame();
    check_pos("pre_rst", 10 + 4 * 7, rise_y(7), 1);
    @(negedge clk) begin
      vblnk = 1'b1;
      rst   = 1'b1;
    end
    @(negedge clk);
    check_pos("mid_rst", 10, 292, 0);
    rst = 1'b0;
    @(negedge clk);
    check_pos("post_rst_tick", 14, 292, 0);
    @(negedge clk);
    check("vblnk_hold2", int'(player_xpos), 14);
    @(negedge clk);
    check("vblnk_hold3", int'(player_xpos), 14);
    vblnk     = 1'b0;
    btn_right = 1'b0;
    repeat (2) @(negedge clk);
    check("after_vblnk", int'(player_xpos), 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
